// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e     : receiver FSM encoding (IDLE/START/DATA/PARITY/STOP)
//   DIV_MIN        : smallest usable clocks-per-bit value
//   DATA_W_DEFAULT : default data bits per frame
//   clamp_div()    : raises a requested clocks-per-bit value to DIV_MIN
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [15:0] DIV_MIN        = 16'd4;
    localparam int          DATA_W_DEFAULT = 8;

    // Below 4 clocks per bit the mid-bit point (div/2 - 1) collapses, so
    // small values are raised to the minimum.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: circular buffer with a registered head output.
//   clock, resetb  : clock, asynchronous active-low reset
//   push_i/push_data_i : write a byte (dropped with overrun_o pulse when full
//                        and not popped in the same cycle)
//   pop_i          : remove head entry (ignored when empty)
//   head_o         : registered copy of the head entry, holds until popped
//   valid_o        : FIFO not empty
//   level_o        : number of stored entries
//   overrun_o      : 1-cycle pulse, one cycle after a dropped push
// FIFO_DEPTH must be a power of two (pointers wrap naturally).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             push_data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             head_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overrun_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
    logic [LVL_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              overrun_q, overrun_d;
    logic              full, do_pop, do_push;

    assign full    = (count_q == DEPTH_L);
    assign do_pop  = pop_i & (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = push_i & (~full | do_pop);
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_comb begin
        count_d   = count_q;
        head_d    = head_q;
        overrun_d = push_i & full & ~do_pop;

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        // Keep head_q equal to the entry that will sit at rd_ptr next cycle.
        if (do_pop) begin
            if (count_q > LVL_W'(1)) begin
                head_d = mem_q[rd_next];
            end else if (do_push) begin
                head_d = push_data_i;
            end
        end else if ((count_q == '0) && do_push) begin
            head_d = push_data_i;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_next;
            end
            count_q   <= count_d;
            head_q    <= head_d;
            overrun_q <= overrun_d;
        end
    end

    assign head_o    = head_q;
    assign valid_o   = (count_q != '0);
    assign level_o   = count_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: input synchronizer, mid-bit sampling FSM and receive FIFO.
//   clock, resetb   : clock, asynchronous active-low reset
//   enable_i        : receiver enable, low aborts a frame in progress
//   clk_div_i       : clocks per bit (values below 4 act as 4), latched per frame
//   rx_i            : asynchronous serial input, idle high, LSB first
//   rx_data_o/rx_valid_o/rx_ready_i : FIFO head, valid/ready pop port
//   fifo_level_o    : FIFO entry count
//   busy_o          : FSM not idle
//   frame_err_o / overrun_err_o / parity_err_o : 1-cycle error pulses
// Valid/ready: a byte is consumed in every cycle where rx_valid_o and
// rx_ready_i are both high; rx_data_o is stable while valid and not ready.
// Build option UART_RX_PARITY_EN adds one even-parity bit between the data
// and stop bits; without it parity_err_o is constant 0.
// DATA_W must be >= 2, SYNC_STAGES >= 2.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          enable_i,
    input  logic [15:0]                   clk_div_i,
    input  logic                          rx_i,
    output logic [DATA_W-1:0]             rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o,
    output logic                          frame_err_o,
    output logic                          overrun_err_o,
    output logic                          parity_err_o
);

    localparam int BCNT_W = $clog2(DATA_W);

    // Synchronizer. sync_vld_q marks when the chain holds real rx_i samples
    // rather than its reset value, so a line that is already low after reset
    // is not mistaken for a falling edge.
    logic [SYNC_STAGES-1:0] sync_q, sync_vld_q;
    logic                   rx_s, rx_s_real;
    logic                   rx_hi_q;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign rx_s_real = sync_vld_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync_q     <= '1;
            sync_vld_q <= '0;
            rx_hi_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_i};
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            if (rx_s_real) begin
                rx_hi_q <= rx_s;
            end
        end
    end

    rx_state_e         state_q, state_d;
    logic [15:0]       timer_q, timer_d;
    logic [15:0]       div_q, div_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              frame_err_q, frame_err_d;
    logic              push;
    logic              tick, start_edge;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    assign tick       = (timer_q == 16'd0);
    assign start_edge = enable_i & rx_s_real & ~rx_s & rx_hi_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    div_d   = clamp_div(clk_div_i);
                    timer_d = (clamp_div(clk_div_i) >> 1) - 16'd1;
                    state_d = ST_START;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        timer_d   = div_q - 16'd1;
                        bit_cnt_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;     // glitch shorter than half a bit
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d   = {rx_s, shreg_q[DATA_W-1:1]};
                    timer_d   = div_q - 16'd1;
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q == BCNT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    // Even parity: data bits plus parity bit hold an even count of ones.
                    par_bad_d    = ^{shreg_q, rx_s};
                    parity_err_d = ^{shreg_q, rx_s};
                    timer_d      = div_q - 16'd1;
                    state_d      = ST_STOP;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch the next start edge.
                if (tick) begin
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push = ~par_bad_q;
`else
                        push = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable_i) begin
            state_d     = ST_IDLE;
            push        = 1'b0;
            frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    uart_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .resetb      (resetb),
        .push_i      (push),
        .push_data_i (shreg_q),
        .pop_i       (rx_valid_o & rx_ready_i),
        .head_o      (rx_data_o),
        .valid_o     (rx_valid_o),
        .level_o     (fifo_level_o),
        .overrun_o   (overrun_err_o)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign frame_err_o = frame_err_q;

endmodule
